// File: rtl/bch_syndrome.sv
// bch_syndrome: serial (63,24) BCH syndrome calculator, S_1..S_2T via Horner over GF(2^6)
module bch_syndrome #(
  parameter int N = 63,
  parameter int T = 7,
  parameter int M = 6,
  parameter logic [M:0] PRIM_POLY = 7'b1000011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [2*T*M-1:0] syndrome,
  output logic             syn_valid,
  output logic             err_detect
);
  localparam int CW = $clog2(N);
  logic [2*T-1:0][M-1:0] acc_q, acc_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*T*M-1:0] syn_q, syn_d;
  logic err_q, err_d, vld_q, vld_d, last;
  // Constant multiply by alpha^p; p is fixed per accumulator so this folds to an XOR matrix
  function automatic logic [M-1:0] mul_pow(input logic [M-1:0] a, input int p);
    logic [M-1:0] r;
    r = a;
    for (int k = 0; k < 2*T; k++)
      if (k < p) r = {r[M-2:0], 1'b0} ^ (r[M-1] ? PRIM_POLY[M-1:0] : '0);
    return r;
  endfunction
  always_comb begin
    last = bit_valid && (cnt_q == CW'(N-1));
    for (int j = 0; j < 2*T; j++) begin
      nxt[j] = mul_pow(acc_q[j], j + 1) ^ {{(M-1){1'b0}}, bit_in};
      acc_d[j] = !bit_valid ? acc_q[j] : last ? '0 : nxt[j];
    end
    cnt_d = !bit_valid ? cnt_q : last ? '0 : cnt_q + CW'(1);
    syn_d = last ? nxt : syn_q;
    err_d = last ? |nxt : err_q;
    vld_d = last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      syn_q <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      syn_q <= syn_d;
      err_q <= err_d;
      vld_q <= vld_d;
    end
  assign syndrome = syn_q;
  assign err_detect = err_q;
  assign syn_valid = vld_q;
endmodule

// File: tb/tb_bch_syndrome.sv
// tb_bch_syndrome: directed vectors checked against a power-sum syndrome model
module tb_bch_syndrome;
  logic clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0;
  logic [83:0] syndrome;
  logic syn_valid, err_detect;
  int checks = 0, failures = 0, cyc = 0, first_acc = 0, n0 = 0, t0 = 0;
  logic [5:0] exp_t [63];
  int log_t [64];
  logic [83:0] exp_q [$];
  int pulse_q [$];
  logic [83:0] hold_syn = '0, e = '0, r1 = '0;
  logic hold_err = 1'b0;
  logic [62:0] cw;
  localparam logic [62:0] ONES = {63{1'b1}};
  localparam logic [62:0] PAT = 63'h2B7C_91E4_05DA_3F61;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bch_syndrome dut (.clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
                    .syndrome(syndrome), .syn_valid(syn_valid), .err_detect(err_detect));

  task automatic chk(input string name, input logic [83:0] act, input logic [83:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic logic [5:0] sj(input logic [83:0] s, input int j);
    return s[6*(j-1) +: 6];
  endfunction

  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    if (a == 0 || b == 0) return 6'd0;
    return exp_t[(log_t[a] + log_t[b]) % 63];
  endfunction

  // S_j = sum of alpha^(i*j) over set coefficients x^i of the received word
  function automatic logic [83:0] syn_of(input logic [62:0] w);
    logic [83:0] s = '0;
    for (int j = 1; j <= 14; j++)
      for (int i = 0; i < 63; i++)
        if (w[i]) s[6*(j-1) +: 6] = s[6*(j-1) +: 6] ^ exp_t[(i*j) % 63];
    return s;
  endfunction

  always @(negedge clk)
    if (!rst) begin
      if (syn_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got syn_valid=1 expected 0");
        end else begin
          e = exp_q.pop_front();
          chk("syndrome", syndrome, e);
          chk("err_detect", 84'(err_detect), 84'(|e));
          hold_syn = e;
          hold_err = |e;
          pulse_q.push_back(cyc);
        end
        for (int j = 1; j <= 7; j++)
          chk("square", 84'(sj(syndrome, 2*j)), 84'(gf_mul(sj(syndrome, j), sj(syndrome, j))));
      end else begin
        chk("hold_syn", syndrome, hold_syn);
        chk("hold_err", 84'(err_detect), 84'(hold_err));
      end
    end

  task automatic drive(input logic b, input logic v);
    @(posedge clk);
    #1;
    bit_in = b;
    bit_valid = v;
  endtask

  task automatic send(input logic [62:0] w, input int nbits, input bit gaps, input bit push);
    if (push) exp_q.push_back(syn_of(w));
    for (int i = 0; i < nbits; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive(1'($urandom_range(0, 1)), 1'b0);
      drive(w[62-i], 1'b1);
      if (i == 0) first_acc = cyc + 1;
    end
  endtask

  task automatic settle();
    drive(1'b0, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_t[0] = 6'd1;
    for (int i = 1; i < 63; i++)
      exp_t[i] = {exp_t[i-1][4:0], 1'b0} ^ (exp_t[i-1][5] ? 6'b000011 : 6'b0);
    for (int i = 0; i < 63; i++) log_t[exp_t[i]] = i;
    chk("alpha6", 84'(exp_t[6]), 84'(6'b000011));
    chk("alpha62", 84'(exp_t[62]), 84'(6'b100001));
    chk("model_x1_s6", 84'(sj(syn_of(63'd2), 6)), 84'(6'b000011));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_syn", syndrome, 84'h0);
    chk("reset_vld", 84'(syn_valid), 84'h0);
    chk("reset_err", 84'(err_detect), 84'h0);
    send(63'd0, 63, 1'b0, 1'b1);
    t0 = first_acc;
    settle();
    chk_int("latency", pulse_q.size() > 0 ? pulse_q[0] - t0 : -1, 62);
    send(63'd1, 63, 1'b0, 1'b1);
    settle();
    chk("x0_all", syndrome, {14{6'b000001}});
    chk("x0_err", 84'(err_detect), 84'h1);
    send(63'd2, 63, 1'b0, 1'b1);
    settle();
    chk("x1_s1", 84'(sj(syndrome, 1)), 84'(6'b000010));
    chk("x1_s2", 84'(sj(syndrome, 2)), 84'(6'b000100));
    chk("x1_s6", 84'(sj(syndrome, 6)), 84'(6'b000011));
    send(63'h4000_0000_0000_0000, 63, 1'b0, 1'b1);
    settle();
    chk("x62_s1", 84'(sj(syndrome, 1)), 84'(6'b100001));
    chk("x62_err", 84'(err_detect), 84'h1);
    n0 = pulse_q.size();
    send(ONES, 63, 1'b0, 1'b1);
    send(ONES, 63, 1'b0, 1'b1);
    settle();
    chk_int("b2b_spacing", pulse_q.size() >= n0 + 2 ? pulse_q[n0+1] - pulse_q[n0] : -1, 63);
    chk("code_syn", syndrome, 84'h0);
    chk("code_err", 84'(err_detect), 84'h0);
    cw = ONES;
    cw[52] = 1'b0;
    send(cw, 63, 1'b0, 1'b1);
    settle();
    chk("flip10_s1", 84'(sj(syndrome, 1)), 84'(exp_t[52]));
    chk("flip10_err", 84'(err_detect), 84'h1);
    send(PAT, 63, 1'b0, 1'b1);
    settle();
    r1 = syndrome;
    send(PAT, 63, 1'b1, 1'b1);
    settle();
    chk("gap_vs_gapless", syndrome, r1);
    send(PAT, 30, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bit_valid = 1'b0;
    hold_syn = '0;
    hold_err = 1'b0;
    #1;
    chk("async_syn", syndrome, 84'h0);
    chk("async_err", 84'(err_detect), 84'h0);
    chk("async_vld", 84'(syn_valid), 84'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(63'd0, 63, 1'b0, 1'b1);
    settle();
    repeat (5) @(negedge clk);
    chk_int("missing_pulses", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
